// File: rtl/led_pkg.sv
// Shared definitions for the port LED controller: global mode encoding,
// default parameter values and the per-channel drive decision.
package led_pkg;

    typedef enum logic [1:0] {
        MODE_NORMAL = 2'b00,
        MODE_LINK   = 2'b01,
        MODE_OFF    = 2'b10,
        MODE_TEST   = 2'b11
    } mode_t;

    localparam int NCH_DEFAULT            = 8;
    localparam int BLINK_HALF_DEFAULT     = 1250000;
    localparam int STRETCH_HALVES_DEFAULT = 4;

    // Returns {led, oe} for one channel given the global mode, the
    // synchronised link-down flag, the stretch activity and the blink phase.
    function automatic logic [1:0] drive_levels(
        input mode_t mode,
        input logic  link_down,
        input logic  active,
        input logic  phase
    );
        logic [1:0] lvl;
        lvl = 2'b00;
        case (mode)
            MODE_NORMAL: begin
                if (link_down) begin
                    lvl = 2'b00;
                end else if (active) begin
                    lvl = {phase, 1'b1};
                end else begin
                    lvl = 2'b11;
                end
            end
            MODE_LINK: lvl = link_down ? 2'b00 : 2'b11;
            MODE_OFF:  lvl = 2'b00;
            default:   lvl = 2'b11;
        endcase
        return lvl;
    endfunction

endpackage

// File: rtl/led_port_ctrl_chan.sv
// One LED channel: link/act synchronisers, act falling-edge detect,
// activity stretch counter and the registered pad drive.
module led_chan
    import led_pkg::*;
#(
    parameter int STRETCH_HALVES = STRETCH_HALVES_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       link,
    input  logic       act,
    input  logic       tick,
    input  logic       blink_phase,
    input  logic [1:0] mode,
    output logic       led,
    output logic       oe
);

    localparam int CW = $clog2(STRETCH_HALVES + 1);
    localparam logic [CW-1:0] RELOAD = CW'(STRETCH_HALVES);

    logic          link_meta;
    logic          link_sync;
    logic          act_meta;
    logic          act_sync;
    logic          act_prev;
    logic          act_fall;
    logic          active;
    logic [CW-1:0] stretch;
    logic [CW-1:0] stretch_next;

    // Two-flop synchronisers plus one history flop for act edge detection.
    // They clear to 0, so link reads as "up" until the first real sample
    // has propagated through.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            link_meta <= 1'b0;
            link_sync <= 1'b0;
            act_meta  <= 1'b0;
            act_sync  <= 1'b0;
            act_prev  <= 1'b0;
        end else begin
            link_meta <= link;
            link_sync <= link_meta;
            act_meta  <= act;
            act_sync  <= act_meta;
            act_prev  <= act_sync;
        end
    end

    // act is active-low, so a new burst starts on a 1->0 transition.
    assign act_fall = act_prev & ~act_sync;

    // Next stretch value: link-down clears, an edge reloads (winning over a
    // coincident tick), otherwise a nonzero count burns one half per tick.
    always_comb begin
        stretch_next = stretch;
        if (link_sync) begin
            stretch_next = '0;
        end else if (act_fall) begin
            stretch_next = RELOAD;
        end else if (tick && (stretch != '0)) begin
            stretch_next = stretch - 1'b1;
        end
    end

    // Stretch counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stretch <= '0;
        end else begin
            stretch <= stretch_next;
        end
    end

    // Decoding from the next-state value keeps input-to-pad latency at the
    // two synchroniser stages plus the output register.
    assign active = (stretch_next != '0);

    // Registered pad drive; mode is already synchronous so it acts next cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            led <= 1'b0;
            oe  <= 1'b0;
        end else begin
            {led, oe} <= drive_levels(mode_t'(mode), link_sync, active, blink_phase);
        end
    end

endmodule

// File: rtl/led_port_ctrl.sv
// Port LED controller top: shared blink prescaler and phase, plus one
// led_chan per port.
module led_port_ctrl
    import led_pkg::*;
#(
    parameter int NCH            = NCH_DEFAULT,
    parameter int BLINK_HALF     = BLINK_HALF_DEFAULT,
    parameter int STRETCH_HALVES = STRETCH_HALVES_DEFAULT
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [NCH-1:0] link,
    input  logic [NCH-1:0] act,
    input  logic [1:0]     mode,
    output logic [NCH-1:0] led_o,
    output logic [NCH-1:0] led_oe
);

    localparam int PW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
    localparam logic [PW-1:0] LAST = PW'(BLINK_HALF - 1);

    logic [PW-1:0] prescale;
    logic          tick;
    logic          blink_phase;

    assign tick = (prescale == LAST);

    // Free-running prescaler, 0..BLINK_HALF-1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prescale <= '0;
        end else if (tick) begin
            prescale <= '0;
        end else begin
            prescale <= prescale + 1'b1;
        end
    end

    // Shared blink phase, toggled once per half-period.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            blink_phase <= 1'b0;
        end else if (tick) begin
            blink_phase <= ~blink_phase;
        end
    end

    for (genvar i = 0; i < NCH; i++) begin : g_chan
        led_chan #(
            .STRETCH_HALVES(STRETCH_HALVES)
        ) u_chan (
            .clk         (clk),
            .rst         (rst),
            .link        (link[i]),
            .act         (act[i]),
            .tick        (tick),
            .blink_phase (blink_phase),
            .mode        (mode),
            .led         (led_o[i]),
            .oe          (led_oe[i])
        );
    end

endmodule

// File: tb/tb_led_port_ctrl.sv
// Scoreboard bench for led_port_ctrl (NCH=4, BLINK_HALF=4, STRETCH_HALVES=2).
// Stimulus pushes the reference model's expected drive for every clock edge;
// a monitor pops and compares on the falling edge.
module tb_led_port_ctrl;

    localparam int NCH = 4;
    localparam int BH  = 4;
    localparam int SH  = 2;

    typedef struct {
        logic [NCH-1:0] led;
        logic [NCH-1:0] oe;
        int             id;
    } exp_t;

    logic           clk = 1'b0;
    logic           rst;
    logic [NCH-1:0] link;
    logic [NCH-1:0] act;
    logic [1:0]     mode;
    logic [NCH-1:0] led_o;
    logic [NCH-1:0] led_oe;

    int vectors     = 0;
    int miscompares = 0;
    int step_no     = 0;

    exp_t           sb[$];
    logic [NCH-1:0] hl[$];
    logic [NCH-1:0] ha[$];
    logic [1:0]     hm[$];
    int             m;
    int             load_t[NCH];

    logic [NCH-1:0] cur_link;
    logic [1:0]     cur_mode;

    led_port_ctrl #(
        .NCH(NCH),
        .BLINK_HALF(BH),
        .STRETCH_HALVES(SH)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .link   (link),
        .act    (act),
        .mode   (mode),
        .led_o  (led_o),
        .led_oe (led_oe)
    );

    always #5 clk = ~clk;

    // Reference: cycle m counts cycles since reset release. Inputs are seen
    // two cycles late; ticks occurring up to cycle m are (m+1)/BH; a burst
    // stays active while fewer than SH ticks have passed since its start.
    function automatic exp_t model_out();
        exp_t e;
        int   ticks = (m + 1) / BH;
        logic phase = ((m / BH) % 2) == 1;
        e.led = '0;
        e.oe  = '0;
        e.id  = step_no;
        for (int ch = 0; ch < NCH; ch++) begin
            logic down;
            logic now_lo;
            logic was_hi;
            logic busy;
            down   = (m >= 2) ? hl[m-2][ch] : 1'b0;
            now_lo = (m >= 2) ? !ha[m-2][ch] : 1'b1;
            was_hi = (m >= 3) ? ha[m-3][ch] : 1'b0;
            if (down) begin
                load_t[ch] = -1;
            end else if (was_hi && now_lo) begin
                load_t[ch] = ticks;
            end
            busy = (load_t[ch] >= 0) && ((ticks - load_t[ch]) < SH);
            case (hm[m])
                2'b00: begin
                    e.oe[ch]  = !down;
                    e.led[ch] = down ? 1'b0 : (busy ? phase : 1'b1);
                end
                2'b01: begin
                    e.oe[ch]  = !down;
                    e.led[ch] = !down;
                end
                2'b10: begin
                    e.oe[ch]  = 1'b0;
                    e.led[ch] = 1'b0;
                end
                default: begin
                    e.oe[ch]  = 1'b1;
                    e.led[ch] = 1'b1;
                end
            endcase
        end
        return e;
    endfunction

    task automatic step(input logic [NCH-1:0] lk, input logic [NCH-1:0] ac,
                        input logic [1:0] md, input logic rs);
        exp_t e;
        @(posedge clk);
        #1;
        step_no++;
        if (rst || rs) begin
            e.led = '0;
            e.oe  = '0;
            e.id  = step_no;
        end else begin
            e = model_out();
        end
        sb.push_back(e);
        if (rs) begin
            rst = 1'b1;
        end else if (rst) begin
            rst = 1'b0;
            hl.delete();
            ha.delete();
            hm.delete();
            m = 0;
            for (int i = 0; i < NCH; i++) load_t[i] = -1;
        end else begin
            m++;
        end
        link = lk;
        act  = ac;
        mode = md;
        if (!rs) begin
            hl.push_back(lk);
            ha.push_back(ac);
            hm.push_back(md);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(cur_link, '1, cur_mode, 1'b0);
    endtask

    task automatic pulse(input logic [NCH-1:0] low_mask);
        step(cur_link, ~low_mask, cur_mode, 1'b0);
    endtask

    // Monitor: one DUT output per clock, compared on the falling edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                vectors++;
                if (led_o !== e.led || led_oe !== e.oe) begin
                    miscompares++;
                    $display("FAIL drive step %0d: got led_o=%b led_oe=%b, want led_o=%b led_oe=%b",
                             e.id, led_o, led_oe, e.led, e.oe);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [NCH-1:0] ac;
        logic [NCH-1:0] prev_ac;
        rst      = 1'b1;
        link     = '1;
        act      = '1;
        mode     = 2'b00;
        m        = 0;
        cur_link = '1;
        cur_mode = 2'b00;
        for (int i = 0; i < NCH; i++) load_t[i] = -1;

        // Reset with all links down, then release and let blink run.
        for (int i = 0; i < 3; i++) step(cur_link, '1, cur_mode, 1'b1);
        idle(11);

        // Port 0 up, single-cycle activity pulse.
        cur_link = 4'hE;
        idle(4);
        pulse(4'h1);
        idle(16);

        // All up; port 1 retriggered five cycles after the first edge.
        cur_link = 4'h0;
        idle(3);
        pulse(4'h2);
        idle(4);
        pulse(4'h2);
        idle(16);

        // Port 2 link lost mid-stretch, then restored.
        pulse(4'h4);
        idle(3);
        cur_link = 4'h4;
        idle(6);
        cur_link = 4'h0;
        idle(12);

        // Mixed link, lamp test then all-off mid-stretch, back to normal.
        cur_link = 4'h5;
        pulse(4'hA);
        idle(2);
        cur_mode = 2'b11;
        idle(2);
        cur_mode = 2'b10;
        idle(2);
        cur_mode = 2'b00;
        idle(10);

        // Held-low activity must not retrigger.
        cur_link = 4'h0;
        for (int i = 0; i < 12; i++) step(cur_link, 4'hE, cur_mode, 1'b0);
        idle(10);

        // Reset mid-stretch.
        pulse(4'hF);
        idle(3);
        step(cur_link, '1, cur_mode, 1'b1);
        step(cur_link, '1, cur_mode, 1'b1);
        idle(16);

        // Randomised traffic.
        prev_ac = '1;
        for (int i = 0; i < 500; i++) begin
            if ($urandom_range(0, 39) == 0) begin
                int k;
                k = $urandom_range(0, NCH - 1);
                cur_link[k] = ~cur_link[k];
            end
            if ($urandom_range(0, 29) == 0) begin
                if ($urandom_range(0, 1) == 0) cur_mode = 2'b00;
                else cur_mode = 2'($urandom_range(0, 3));
            end
            ac = '1;
            for (int ch = 0; ch < NCH; ch++) begin
                if (!prev_ac[ch] && $urandom_range(0, 1) == 0) ac[ch] = 1'b0;
                else if ($urandom_range(0, 7) == 0) ac[ch] = 1'b0;
            end
            prev_ac = ac;
            step(cur_link, ac, cur_mode, 1'b0);
        end
        idle(4);

        @(negedge clk);
        #1;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL drain: got %0d pending, want 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
